// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO behind uart_rx.
// Captures single-cycle rx_valid strobes into a circular buffer and presents
// the head byte on a first-word-fall-through valid/ready port. Tracks
// overflow / framing-error / break events in sticky flags and raises
// level_irq when occupancy reaches Threshold.
module uart_rx_fifo #(
   parameter int Depth     = 16,
   parameter int Threshold = 8,
   localparam int CW       = $clog2(Depth + 1),
   localparam int AW       = $clog2(Depth)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          rx_break,
   input  logic          rx_error,
   output logic [7:0]    data_out,
   output logic          data_out_valid,
   input  logic          data_out_ready,
   output logic [CW-1:0] count,
   output logic          level_irq,
   output logic          overflow,
   output logic          frame_error,
   output logic          break_seen,
   input  logic          clear_flags,
   input  logic          flush
);

   localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
   localparam logic [CW-1:0] THRSH_C = CW'(Threshold);

   logic [7:0]    r_mem [Depth];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic          r_frame_error;
   logic          r_break_seen;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;

   // Occupancy-derived status; flush overrides any same-cycle push/pop.
   // A full FIFO still accepts a byte when the head is leaving this cycle.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == DEPTH_C);
   assign w_pop   = !w_empty && data_out_ready && !flush;
   assign w_push  = rx_valid && (!w_full || w_pop) && !flush;
   assign w_drop  = rx_valid && w_full && !w_pop && !flush;

   // Byte storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= rx_data;
   end

   // Pointers and occupancy; pointers wrap naturally at Depth (power of two).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky event flags; an event in the same cycle as clear_flags wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow    <= 1'b0;
         r_frame_error <= 1'b0;
         r_break_seen  <= 1'b0;
      end else begin
         r_overflow    <= w_drop   || (r_overflow    && !clear_flags);
         r_frame_error <= rx_error || (r_frame_error && !clear_flags);
         r_break_seen  <= rx_break || (r_break_seen  && !clear_flags);
      end
   end

   // Outputs depend only on registered state; data_out is forced to zero
   // while empty so a reset or flush never exposes stale bytes.
   assign data_out_valid = !w_empty;
   assign data_out       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign count          = r_count;
   assign level_irq      = (r_count >= THRSH_C);
   assign overflow       = r_overflow;
   assign frame_error    = r_frame_error;
   assign break_seen     = r_break_seen;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard queue.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid, rx_break, rx_error;
   logic [7:0] data_out;
   logic       data_out_valid, data_out_ready;
   logic [4:0] count;
   logic       level_irq, overflow, frame_error, break_seen;
   logic       clear_flags, flush;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb[$];

   uart_rx_fifo #(.Depth(16), .Threshold(8)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_break(rx_break), .rx_error(rx_error), .data_out(data_out),
      .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .count(count), .level_irq(level_irq), .overflow(overflow),
      .frame_error(frame_error), .break_seen(break_seen),
      .clear_flags(clear_flags), .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push one byte with no pop; scoreboard keeps it only if there is room.
   task automatic push_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (sb.size() < 16) sb.push_back(b);
   endtask

   // Pop everything the scoreboard expects, checking order, then emptiness.
   task automatic drain(input string tag);
      logic [7:0] e;
      data_out_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         e = sb.pop_front();
         chk({tag, "_valid"}, data_out_valid, 1'b1);
         chk({tag, "_data"}, data_out, e);
         tick();
      end
      data_out_ready = 1'b0;
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_valid_fall"}, data_out_valid, 1'b0);
      chk({tag, "_count0"}, count, 0);
   endtask

   initial begin
      string hello;
      hello = "Hello world\n";
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_break = 1'b0;
      rx_error = 1'b0; data_out_ready = 1'b0; clear_flags = 1'b0; flush = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_count", count, 0);
      chk("rst_valid", data_out_valid, 0);
      chk("rst_irq", level_irq, 0);
      chk("rst_flags", {overflow, frame_error, break_seen}, 3'b000);

      // Hello world: level_irq crosses at the 8th byte
      for (int i = 0; i < 12; i++) begin
         push_byte(hello[i]);
         if (i == 6) chk("hello_irq_7", level_irq, 1'b0);
         if (i == 7) chk("hello_irq_8", level_irq, 1'b1);
      end
      chk("hello_count", count, 12);
      chk("hello_head", data_out, 8'h48);
      drain("hello");

      // 17 pushes into 16 entries: last byte dropped
      for (int i = 0; i < 17; i++) begin
         push_byte(8'(i));
         if (i == 15) chk("ovf_before", overflow, 1'b0);
      end
      chk("ovf_count", count, 16);
      chk("ovf_flag", overflow, 1'b1);
      drain("ovf");
      chk("ovf_sticky", overflow, 1'b1);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      chk("ovf_cleared", overflow, 1'b0);

      // Full plus simultaneous push/pop
      for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
      rx_data = 8'hAA; rx_valid = 1'b1; data_out_ready = 1'b1;
      chk("full_pp_head", data_out, sb.pop_front());
      sb.push_back(8'hAA);
      tick();
      rx_valid = 1'b0; data_out_ready = 1'b0;
      chk("full_pp_count", count, 16);
      chk("full_pp_ovf", overflow, 1'b0);
      drain("full_pp");

      // Sticky flags
      rx_error = 1'b1; tick(); rx_error = 1'b0;
      chk("ferr_set", {frame_error, break_seen}, 2'b10);
      rx_break = 1'b1; tick(); rx_break = 1'b0;
      chk("brk_set", {frame_error, break_seen}, 2'b11);
      chk("err_no_push", count, 0);
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;
      chk("flags_clr", {frame_error, break_seen}, 2'b00);
      rx_error = 1'b1; clear_flags = 1'b1; tick();
      rx_error = 1'b0; clear_flags = 1'b0;
      chk("ferr_set_wins", frame_error, 1'b1);
      rx_data = 8'h3C; rx_valid = 1'b1; rx_error = 1'b1; tick();
      rx_valid = 1'b0; rx_error = 1'b0; sb.push_back(8'h3C);
      chk("err_with_push_cnt", count, 1);
      drain("err_push");
      clear_flags = 1'b1; tick(); clear_flags = 1'b0;

      // Flush with simultaneous push
      for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
      rx_data = 8'h55; rx_valid = 1'b1; flush = 1'b1; tick();
      rx_valid = 1'b0; flush = 1'b0;
      sb.delete();
      chk("flush_count", count, 0);
      chk("flush_valid", data_out_valid, 1'b0);
      chk("flush_ovf", overflow, 1'b0);
      push_byte(8'h66);
      chk("flush_next_head", data_out, 8'h66);
      drain("flush");

      // Build 7 buffered bytes with overflow set, then async reset
      for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i));
      data_out_ready = 1'b1;
      repeat (9) begin
         chk("pre_rst_data", data_out, sb.pop_front());
         tick();
      end
      data_out_ready = 1'b0;
      chk("pre_rst_count", count, 7);
      chk("pre_rst_ovf", overflow, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_valid", data_out_valid, 1'b0);
      chk("async_rst_outs", {level_irq, overflow, frame_error, break_seen}, 4'b0000);
      sb.delete();
      tick();
      rst = 1'b0;
      tick();

      // 40-byte stream with continuous drain, wrapping the pointers
      data_out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         chk("stream_valid", data_out_valid, sb.size() != 0);
         if (sb.size() != 0) chk("stream_data", data_out, sb.pop_front());
         rx_data = 8'hC0 ^ 8'(i * 7);
         rx_valid = 1'b1;
         sb.push_back(rx_data);
         tick();
      end
      rx_valid = 1'b0;
      drain("stream");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of `uart_rx`. Captures each byte pulsed out by the receiver into a circular FIFO and presents it to the consumer (CPU bus bridge or testbench) through a first-word-fall-through valid/ready port. Records overflow, framing-error and break events in sticky status flags, and exposes a fill-level threshold for interrupt generation. Decouples the receiver's single-cycle `data_valid` pulse from consumer back-pressure.

## Interface

- `Depth`, 16 — number of byte entries; power of two, ≥ 2.
- `Threshold`, 8 — `level_irq` asserts when occupancy ≥ this value; 1 ≤ Threshold ≤ Depth.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  byte from `uart_rx.data_out`.
- `rx_valid`  in  1  single-cycle strobe from `uart_rx.data_valid`.
- `rx_break`  in  1  from `uart_rx.break_received`.
- `rx_error`  in  1  from `uart_rx.error`.
- `data_out`  out  8  byte at FIFO head; meaningful only while `data_out_valid`.
- `data_out_valid`  out  1  FIFO non-empty.
- `data_out_ready`  in  1  consumer accepts head byte when high together with `data_out_valid`.
- `count`  out  $clog2(Depth+1)  current occupancy, 0..Depth.
- `level_irq`  out  1  `count >= Threshold`.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frame_error`  out  1  sticky: `rx_error` seen.
- `break_seen`  out  1  sticky: `rx_break` seen.
- `clear_flags`  in  1  clears the three sticky flags.
- `flush`  in  1  discards all buffered bytes.

## Operation

- Storage: `Depth` × 8-bit array, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(Depth) bits; pointers wrap modulo Depth naturally. Occupancy held in `count` register (not derived from pointers).
- Push: `rx_valid` high and (`count < Depth` or pop this cycle) → write `rx_data` at `wr_ptr`, increment `wr_ptr`.
- Pop: `data_out_valid && data_out_ready` → increment `rd_ptr`.
- `count` next = count + push − pop. Push and pop in the same cycle leave `count` unchanged, including when full (byte accepted) and when count = 1.
- Full, `rx_valid` high, no pop → byte dropped, pointers and array unchanged, `overflow` ← 1.
- Empty, `data_out_ready` high → no effect (no underflow, `rd_ptr` unchanged).
- `data_out = mem[rd_ptr]` (combinational read of registered storage); no combinational path from any input to any output except none — `data_out_ready` does not affect outputs in the same cycle.
- `flush` high: `wr_ptr`, `rd_ptr`, `count` ← 0 next edge; a simultaneous push or pop is ignored; no overflow flagged. Sticky flags unaffected by `flush`.
- Sticky flags: set on their event each cycle; `clear_flags` clears; simultaneous event and `clear_flags` → flag stays/becomes 1 (set wins).
- `rx_error` and `rx_break` only set flags; they never push data, even if `rx_valid` coincides (the byte is still pushed normally in that case).

## Timing

- Reset (async assert, sync-safe release): `wr_ptr`, `rd_ptr`, `count` = 0; `data_out_valid`, `level_irq`, `overflow`, `frame_error`, `break_seen` = 0; array contents undefined; `data_out` undefined but `data_out_valid` = 0. Reset mid-stream discards all bytes and flags immediately.
- Push latency: `rx_valid` sampled at edge N → `data_out_valid`, `count`, `data_out` (if previously empty) updated after edge N.
- Pop: accepted at edge N → next byte (or `data_out_valid` = 0) visible after edge N; back-to-back pops sustain 1 byte/cycle.
- `level_irq`, flags: registered or derived from registered `count`; change only after a clock edge.
- Throughput: one push and one pop per cycle simultaneously.

## Test plan

- Write 12 bytes "Hello world\n" with `data_out_ready`=0, Depth 16 → `count`=12, `level_irq`=1 after 8th push; then drain with ready=1 → bytes out in order, `count` reaches 0, `data_out_valid` falls after last pop.
- Push 17 bytes 0x00..0x10 with no pops → `count`=16, `overflow`=1 after 17th, drained data 0x00..0x0F, 0x10 absent.
- Fill to 16, then push 0xAA with simultaneous pop → `count` stays 16, `overflow`=0, 0xAA is last byte drained.
- Pulse `rx_error` and `rx_break` → flags set; `clear_flags` alone clears them; `clear_flags` same cycle as `rx_error` → `frame_error` remains 1.
- Push 5 bytes, assert `flush` together with a push of 0x55 → `count`=0, `data_out_valid`=0, next push 0x66 appears as head.
- Assert `rst` with 7 bytes buffered and `overflow`=1 → all outputs zero immediately, before next clock edge; push after release wraps pointers correctly over ≥ 40 bytes with continuous drain.
